// File: rtl/sfifo_wr_gen_if.sv
// Control, status and FIFO write-port signals for the sfifo write-side traffic generator.
// The master modport is the generator; the slave modport is the controller and FIFO side.
interface sfifo_wr_gen_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16
);
  logic          start;
  logic          abort;
  logic          mode;
  logic [DW-1:0] seed;
  logic [CW-1:0] len;
  logic [CW-1:0] gap;
  logic          full;
  logic          ovfl;
  logic          wr_out;
  logic [DW-1:0] din_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] wr_count;
  logic          err;

  modport master (
    input  start, abort, mode, seed, len, gap, full, ovfl,
    output wr_out, din_out, busy, done, wr_count, err
  );

  modport slave (
    output start, abort, mode, seed, len, gap, full, ovfl,
    input  wr_out, din_out, busy, done, wr_count, err
  );
endinterface

// File: rtl/sfifo_wr_gen.sv
// Write-side traffic generator for sfifo: emits len words (incrementing or 16-bit LFSR)
// gated by full, with a programmable idle gap after each accepted word.
module sfifo_wr_gen #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16
) (
  input logic              clk,
  input logic              rst,
  sfifo_wr_gen_if.master   bus_io
);

  typedef enum logic [1:0] {StIdle, StWrite, StGap, StDone} state_e;

  state_e        state_q;
  logic          mode_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] gap_q;
  logic [CW-1:0] gap_cnt_q;
  logic [CW-1:0] wr_count_q;
  logic [DW-1:0] data_q;
  logic          err_q;

  logic          accept;
  logic          busy;
  logic [CW-1:0] count_inc;
  logic [DW-1:0] data_next;

  // abort masks the write in the same cycle so no word is accepted on that edge
  assign accept    = (state_q == StWrite) && !bus_io.full && !bus_io.abort;
  assign busy      = (state_q == StWrite) || (state_q == StGap);
  assign count_inc = wr_count_q + CW'(1);
  assign data_next = mode_q ? {data_q[14:0], data_q[15] ^ data_q[13] ^ data_q[12] ^ data_q[10]}
                            : data_q + DW'(1);

  assign bus_io.wr_out   = accept;
  assign bus_io.din_out  = data_q;
  assign bus_io.busy     = busy;
  assign bus_io.done     = (state_q == StDone);
  assign bus_io.wr_count = wr_count_q;
  assign bus_io.err      = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      len_q      <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      wr_count_q <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (bus_io.ovfl && busy) begin
        err_q <= 1'b1;
      end
      if (bus_io.abort) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (bus_io.start) begin
              mode_q     <= bus_io.mode;
              len_q      <= bus_io.len;
              gap_q      <= bus_io.gap;
              // an all-zero LFSR would lock up, so substitute 1
              data_q     <= (bus_io.mode && bus_io.seed == '0) ? DW'(1) : bus_io.seed;
              wr_count_q <= '0;
              err_q      <= 1'b0;
              state_q    <= (bus_io.len == '0) ? StDone : StWrite;
            end
          end
          StWrite: begin
            if (accept) begin
              wr_count_q <= count_inc;
              data_q     <= data_next;
              if (count_inc == len_q) begin
                state_q <= StDone;
              end else if (gap_q != '0) begin
                gap_cnt_q <= gap_q;
                state_q   <= StGap;
              end
            end
          end
          StGap: begin
            gap_cnt_q <= gap_cnt_q - CW'(1);
            if (gap_cnt_q <= CW'(1)) begin
              state_q <= StWrite;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sfifo_wr_gen.sv
// Self-checking bench for sfifo_wr_gen: directed scenarios plus randomized runs against a
// sequence-level reference model and a behavioural FIFO for the closed-loop check.
module tb_sfifo_wr_gen;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  sfifo_wr_gen_if #(.DW(16), .CW(16)) bus ();

  sfifo_wr_gen #(.DW(16), .CW(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] got_w[$];
  int          got_c[$];
  logic [15:0] din_seen[$];
  int          exp_c[$];
  int          done_at;

  // Word i of a sequence, straight from the pattern rules.
  function automatic logic [15:0] model_word(input logic m, input logic [15:0] s, input int i);
    logic [15:0] x;
    if (!m) return 16'((32'(s) + i) % 65536);
    x = (s == 16'h0) ? 16'h0001 : s;
    for (int k = 0; k < i; k++) x = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    return x;
  endfunction

  // Cycles (relative to the first cycle after start) at which words should be accepted.
  task automatic model_cycles(input int l, input int g, input logic [63:0] fm);
    int t;
    exp_c.delete();
    t = 0;
    for (int k = 0; k < l; k++) begin
      while (t < 64 && fm[t]) t++;
      exp_c.push_back(t);
      t += g + 1;
    end
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic start_seq(input logic m, input logic [15:0] s, input logic [15:0] l,
                           input logic [15:0] g);
    half();
    bus.mode  = m;
    bus.seed  = s;
    bus.len   = l;
    bus.gap   = g;
    bus.full  = 1'b0;
    bus.start = 1'b1;
  endtask

  task automatic collect(input int n, input logic [63:0] fm);
    got_w.delete();
    got_c.delete();
    din_seen.delete();
    done_at = -1;
    for (int c = 0; c < n; c++) begin
      half();
      bus.start = 1'b0;
      bus.full  = (c < 64) ? fm[c] : 1'b0;
      #1;
      din_seen.push_back(bus.din_out);
      if (bus.wr_out === 1'b1) begin
        got_w.push_back(bus.din_out);
        got_c.push_back(c);
      end
      if (bus.done === 1'b1 && done_at < 0) done_at = c;
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({bus.wr_out, bus.din_out, bus.busy, bus.done, bus.wr_count, bus.err} !== 35'h0) begin
      fails++;
      $display("FAIL reset_outputs: got wr=%b din=%h busy=%b done=%b cnt=%0d err=%b, want all 0",
               bus.wr_out, bus.din_out, bus.busy, bus.done, bus.wr_count, bus.err);
    end
  endtask

  task automatic test_inc_b2b();
    start_seq(1'b0, 16'h0010, 16'd4, 16'd0);
    collect(8, 64'h0);
    model_cycles(4, 0, 64'h0);
    tests++;
    if (got_w.size() != 4) begin
      fails++;
      $display("FAIL inc_count: got %0d words, want 4", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 4; i++) begin
      tests++;
      if (got_w[i] !== model_word(1'b0, 16'h0010, i) || got_c[i] != exp_c[i]) begin
        fails++;
        $display("FAIL inc_word%0d: got %h@%0d, want %h@%0d", i, got_w[i], got_c[i],
                 model_word(1'b0, 16'h0010, i), exp_c[i]);
      end
    end
    tests++;
    if (done_at != 4 || bus.wr_count !== 16'd4 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL inc_done: got done@%0d cnt=%0d busy=%b, want done@4 cnt=4 busy=0",
               done_at, bus.wr_count, bus.busy);
    end
  endtask

  task automatic test_lfsr_gap();
    logic [15:0] want[3] = '{16'h0001, 16'h0002, 16'h0004};
    int          wc[3] = '{0, 3, 6};
    start_seq(1'b1, 16'h0000, 16'd3, 16'd2);
    collect(12, 64'h0);
    tests++;
    if (got_w.size() != 3) begin
      fails++;
      $display("FAIL lfsr_count: got %0d words, want 3", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 3; i++) begin
      tests++;
      if (got_w[i] !== want[i] || got_c[i] != wc[i]) begin
        fails++;
        $display("FAIL lfsr_word%0d: got %h@%0d, want %h@%0d", i, got_w[i], got_c[i],
                 want[i], wc[i]);
      end
    end
    tests++;
    if (done_at != 7) begin
      fails++;
      $display("FAIL lfsr_done: got done@%0d, want done@7", done_at);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] fm = 64'h38;
    start_seq(1'b0, 16'h1230, 16'd8, 16'd0);
    collect(16, fm);
    model_cycles(8, 0, fm);
    tests++;
    if (got_w.size() != 8) begin
      fails++;
      $display("FAIL bp_count: got %0d words, want 8", got_w.size());
    end
    for (int i = 0; i < got_w.size() && i < 8; i++) begin
      tests++;
      if (got_w[i] !== model_word(1'b0, 16'h1230, i) || got_c[i] != exp_c[i]) begin
        fails++;
        $display("FAIL bp_word%0d: got %h@%0d, want %h@%0d", i, got_w[i], got_c[i],
                 model_word(1'b0, 16'h1230, i), exp_c[i]);
      end
    end
    tests++;
    if (din_seen[4] !== 16'h1233 || din_seen[5] !== 16'h1233) begin
      fails++;
      $display("FAIL bp_hold: got din %h,%h while full, want 1233", din_seen[4], din_seen[5]);
    end
    tests++;
    if (bus.wr_count !== 16'd8 || bus.err !== 1'b0 || bus.done !== 1'b1) begin
      fails++;
      $display("FAIL bp_end: got cnt=%0d err=%b done=%b, want 8 0 1",
               bus.wr_count, bus.err, bus.done);
    end
  endtask

  task automatic test_wrap_zero_len();
    start_seq(1'b0, 16'hFFFE, 16'd3, 16'd0);
    collect(6, 64'h0);
    tests++;
    if (got_w.size() != 3 || got_w[0] !== 16'hFFFE || got_w[1] !== 16'hFFFF
        || got_w[2] !== 16'h0000) begin
      fails++;
      $display("FAIL wrap_words: got %0d words %p, want FFFE FFFF 0000", got_w.size(), got_w);
    end
    start_seq(1'b0, 16'h0005, 16'd0, 16'd0);
    collect(3, 64'h0);
    tests++;
    if (got_w.size() != 0 || done_at != 0 || bus.wr_count !== 16'd0) begin
      fails++;
      $display("FAIL zero_len: got %0d writes done@%0d cnt=%0d, want 0 writes done@0 cnt=0",
               got_w.size(), done_at, bus.wr_count);
    end
  endtask

  task automatic test_abort_reset();
    start_seq(1'b0, 16'h0400, 16'd10, 16'd0);
    collect(2, 64'h0);
    half();
    bus.abort = 1'b1;
    #1;
    tests++;
    if (bus.wr_out !== 1'b0) begin
      fails++;
      $display("FAIL abort_gate: got wr=%b, want 0", bus.wr_out);
    end
    half();
    bus.abort = 1'b0;
    #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_count !== 16'd2) begin
      fails++;
      $display("FAIL abort_state: got busy=%b done=%b cnt=%0d, want 0 0 2",
               bus.busy, bus.done, bus.wr_count);
    end
    collect(5, 64'h0);
    tests++;
    if (got_w.size() != 0) begin
      fails++;
      $display("FAIL abort_quiet: got %0d writes after abort, want 0", got_w.size());
    end
    start_seq(1'b0, 16'h0500, 16'd10, 16'd0);
    collect(3, 64'h0);
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({bus.wr_out, bus.din_out, bus.busy, bus.done, bus.wr_count, bus.err} !== 35'h0) begin
      fails++;
      $display("FAIL async_reset: got wr=%b din=%h busy=%b done=%b cnt=%0d err=%b, want 0",
               bus.wr_out, bus.din_out, bus.busy, bus.done, bus.wr_count, bus.err);
    end
    half();
    half();
    rst = 1'b1;
  endtask

  task automatic test_overflow();
    start_seq(1'b0, 16'h0100, 16'd6, 16'd1);
    collect(3, 64'h0);
    half();
    bus.ovfl = 1'b1;
    half();
    bus.ovfl = 1'b0;
    collect(20, 64'h0);
    tests++;
    if (bus.err !== 1'b1 || bus.done !== 1'b1) begin
      fails++;
      $display("FAIL ovfl_sticky: got err=%b done=%b, want 1 1", bus.err, bus.done);
    end
    start_seq(1'b0, 16'h0200, 16'd2, 16'd0);
    collect(1, 64'h0);
    tests++;
    if (bus.err !== 1'b0) begin
      fails++;
      $display("FAIL ovfl_clear: got err=%b after start, want 0", bus.err);
    end
    collect(4, 64'h0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic        m;
      logic [15:0] s;
      int          l;
      int          g;
      logic [63:0] fm;
      m  = 1'($urandom_range(1, 0));
      s  = 16'($urandom);
      l  = $urandom_range(8, 1);
      g  = $urandom_range(3, 0);
      fm = '0;
      for (int b = 0; b < 24; b++) fm[b] = ($urandom_range(3, 0) == 0);
      start_seq(m, s, 16'(l), 16'(g));
      collect(64, fm);
      model_cycles(l, g, fm);
      tests++;
      if (got_w.size() != l) begin
        fails++;
        $display("FAIL rand%0d_count: got %0d words, want %0d", r, got_w.size(), l);
      end
      for (int i = 0; i < got_w.size() && i < l; i++) begin
        tests++;
        if (got_w[i] !== model_word(m, s, i) || got_c[i] != exp_c[i]) begin
          fails++;
          $display("FAIL rand%0d_word%0d: got %h@%0d, want %h@%0d", r, i, got_w[i], got_c[i],
                   model_word(m, s, i), exp_c[i]);
        end
      end
      tests++;
      if (done_at != exp_c[l-1] + 1 || bus.wr_count !== 16'(l)) begin
        fails++;
        $display("FAIL rand%0d_done: got done@%0d cnt=%0d, want done@%0d cnt=%0d", r, done_at,
                 bus.wr_count, exp_c[l-1] + 1, l);
      end
    end
  endtask

  task automatic test_closed_loop();
    logic [15:0] fq[$];
    logic [15:0] s;
    logic [15:0] want;
    int          nread = 0;
    int          rd_err = 0;
    int          ovf = 0;
    int          udf = 0;
    s = 16'($urandom);
    start_seq(1'b1, s, 16'd200, 16'd0);
    want = model_word(1'b1, s, 0);
    for (int c = 0; c < 3000 && nread < 200; c++) begin
      half();
      bus.start = 1'b0;
      bus.full  = (fq.size() >= 8);
      #1;
      if (fq.size() > 0 && $urandom_range(1, 0) == 1) begin
        if (fq[0] !== want) rd_err++;
        void'(fq.pop_front());
        nread++;
        want = {want[14:0], want[15] ^ want[13] ^ want[12] ^ want[10]};
      end
      if (bus.wr_out === 1'b1) begin
        if (fq.size() >= 8) ovf++;
        else fq.push_back(bus.din_out);
      end
    end
    tests++;
    if (nread != 200 || rd_err != 0 || ovf != 0 || udf != 0) begin
      fails++;
      $display("FAIL closed_loop: got reads=%0d rd_err=%0d ovfl=%0d udfl=%0d, want 200 0 0 0",
               nread, rd_err, ovf, udf);
    end
    tests++;
    if (bus.wr_count !== 16'd200 || bus.done !== 1'b1) begin
      fails++;
      $display("FAIL closed_loop_end: got cnt=%0d done=%b, want 200 1", bus.wr_count, bus.done);
    end
  endtask

  initial begin
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mode  = 1'b0;
    bus.seed  = '0;
    bus.len   = '0;
    bus.gap   = '0;
    bus.full  = 1'b0;
    bus.ovfl  = 1'b0;
    half();
    half();
    test_reset();
    half();
    rst = 1'b1;
    test_inc_b2b();
    test_lfsr_gap();
    test_backpressure();
    test_wrap_zero_len();
    test_abort_reset();
    test_overflow();
    test_random();
    test_closed_loop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
